motion_seg_sched: RTL and testbench

Motion segment scheduler for the CNC controller. The host, over Avalon-MM, queues timed motion segments. Each segment carries a step period, a direction and an enable for each of the 5 axes, plus a duration in clock ticks. The block buffers segments in a FIFO and drives the step-generator configuration (period/dir/enable) segment by segment, with no gap between consecutive segments. This lets the host stream moves ahead of time instead of rewriting rate registers in real time. It sits between the Avalon bus and the 5 step_gen instances, replacing direct host writes of per-axis period/dir/enable.

---
 rtl/cnc_pkg.sv | 42 ++++
 rtl/seg_fifo.sv | 57 +++++
 rtl/motion_seg_sched.sv | 191 +++++++++++++++++++
 tb/tb_motion_seg_sched.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnc_pkg.sv
// Shared types and constants for the CNC motion segment scheduler:
// segment layout, Avalon register map and control/status bit positions.
package cnc_pkg;
  localparam int NUM_AXES = 5;
  localparam int PER_W    = 32;
  localparam int DUR_W    = 32;
  localparam int SEG_W    = NUM_AXES*PER_W + 2*NUM_AXES + DUR_W;

  localparam logic [3:0] ADDR_PER0   = 4'd0;
  localparam logic [3:0] ADDR_DIRENS = 4'd5;
  localparam logic [3:0] ADDR_DUR    = 4'd6;
  localparam logic [3:0] ADDR_PUSH   = 4'd7;
  localparam logic [3:0] ADDR_CTRL   = 4'd8;
  localparam logic [3:0] ADDR_STATUS = 4'd9;

  localparam int CTRL_RUN    = 0;
  localparam int CTRL_ABORT  = 1;
  localparam int CTRL_CLR_UR = 2;
  localparam int CTRL_CLR_OV = 3;

  localparam int ST_BUSY     = 8;
  localparam int ST_UNDERRUN = 9;
  localparam int ST_OVERFLOW = 10;

  localparam int DIRS_LSB = 0;
  localparam int ENS_LSB  = 5;

  // First field lands in the MSBs: {dur, ens, dirs, per}.
  typedef struct packed {
    logic [DUR_W-1:0]          dur;
    logic [NUM_AXES-1:0]       ens;
    logic [NUM_AXES-1:0]       dirs;
    logic [NUM_AXES*PER_W-1:0] per;
  } seg_t;

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  // A zero duration still occupies one cycle.
  function automatic logic [DUR_W-1:0] seg_len(input logic [DUR_W-1:0] d);
    return (d == '0) ? DUR_W'(1) : d;
  endfunction
endpackage

// File: rtl/seg_fifo.sv
// Synchronous segment FIFO with flush; a push while full is accepted only
// when a pop happens on the same edge, otherwise it is dropped.
module seg_fifo
  import cnc_pkg::*;
#(
  parameter int W     = SEG_W,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q;
  logic          do_push, do_pop;

  assign empty   = (level_q == '0);
  assign full    = (level_q == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign level   = level_q;
  assign dout    = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage needs no reset: pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= din;
  end
endmodule

// File: rtl/motion_seg_sched.sv
// Motion segment scheduler: host stages and queues timed segments over Avalon-MM,
// the block plays them back-to-back onto the five step generator configs.
module motion_seg_sched
  import cnc_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int LOW_WM = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        chipselect,
  input  logic        read,
  input  logic        write,
  input  logic [3:0]  address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [159:0] sg_period,
  output logic [4:0]  sg_dirs,
  output logic [4:0]  sg_ens,
  output logic        seg_done,
  output logic        irq
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LOW_WM_L = (AW+1)'(LOW_WM);

  logic [NUM_AXES*PER_W-1:0] stg_per_q;
  logic [NUM_AXES-1:0]       stg_dirs_q, stg_ens_q;
  logic [DUR_W-1:0]          stg_dur_q;

  state_t                    state_q, state_d;
  logic [DUR_W-1:0]          cnt_q, cnt_d;
  logic                      run_q, run_d;
  logic [NUM_AXES*PER_W-1:0] per_q, per_d;
  logic [NUM_AXES-1:0]       dirs_q, dirs_d, ens_q, ens_d;
  logic                      done_q, done_d;
  logic                      underrun_q, underrun_d, overflow_q, overflow_d;
  logic [31:0]               readdata_q, rd_dat;

  logic wr_en, rd_en, ctrl_wr, abort, push, pop, load, underrun_hit;
  logic [SEG_W-1:0] push_dat, fifo_dout;
  logic [AW:0]      fifo_level;
  logic             fifo_full, fifo_empty;
  seg_t             head;

  assign wr_en    = chipselect & write;
  assign rd_en    = chipselect & read;
  assign ctrl_wr  = wr_en && (address == ADDR_CTRL);
  assign abort    = ctrl_wr && writedata[CTRL_ABORT];
  assign push     = wr_en && (address == ADDR_PUSH) && !abort;
  assign push_dat = {stg_dur_q, stg_ens_q, stg_dirs_q, stg_per_q};
  assign head     = seg_t'(fifo_dout);

  seg_fifo #(.W(SEG_W), .DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (push),
    .pop    (pop),
    .flush  (abort),
    .din    (push_dat),
    .dout   (fifo_dout),
    .level  (fifo_level),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    run_d        = run_q;
    per_d        = per_q;
    dirs_d       = dirs_q;
    ens_d        = ens_q;
    done_d       = 1'b0;
    load         = 1'b0;
    underrun_hit = 1'b0;
    if (ctrl_wr) run_d = writedata[CTRL_RUN];
    if (abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      run_d   = 1'b0;
      ens_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (run_q && !fifo_empty) begin
            load    = 1'b1;
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == DUR_W'(1)) begin
            done_d = 1'b1;
            if (run_q && !fifo_empty) begin
              load = 1'b1;
            end else begin
              // Dropping run mid-segment is a graceful stop, not an underrun.
              ens_d   = '0;
              state_d = S_IDLE;
              if (run_q) begin
                underrun_hit = 1'b1;
                run_d        = 1'b0;
              end
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    pop = load;
    if (load) begin
      per_d  = head.per;
      dirs_d = head.dirs;
      ens_d  = head.ens;
      cnt_d  = seg_len(head.dur);
    end
  end

  always_comb begin
    underrun_d = underrun_q;
    overflow_d = overflow_q;
    if (ctrl_wr && writedata[CTRL_CLR_UR]) underrun_d = 1'b0;
    if (ctrl_wr && writedata[CTRL_CLR_OV]) overflow_d = 1'b0;
    if (underrun_hit) underrun_d = 1'b1;
    if (push && fifo_full && !pop) overflow_d = 1'b1;
  end

  always_comb begin
    rd_dat = '0;
    if (address < 4'(NUM_AXES)) begin
      rd_dat = stg_per_q[PER_W*int'(address) +: PER_W];
    end else begin
      case (address)
        ADDR_DIRENS: rd_dat = {22'd0, stg_ens_q, stg_dirs_q};
        ADDR_DUR:    rd_dat = stg_dur_q;
        ADDR_CTRL:   rd_dat = {31'd0, run_q};
        ADDR_STATUS: rd_dat = {21'd0, overflow_q, underrun_q, (state_q == S_RUN), 8'(fifo_level)};
        default:     rd_dat = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      run_q      <= 1'b0;
      per_q      <= '0;
      dirs_q     <= '0;
      ens_q      <= '0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
      readdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      run_q      <= run_d;
      per_q      <= per_d;
      dirs_q     <= dirs_d;
      ens_q      <= ens_d;
      done_q     <= done_d;
      underrun_q <= underrun_d;
      overflow_q <= overflow_d;
      if (rd_en) readdata_q <= rd_dat;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stg_per_q  <= '0;
      stg_dirs_q <= '0;
      stg_ens_q  <= '0;
      stg_dur_q  <= '0;
    end else if (wr_en) begin
      if (address < 4'(NUM_AXES)) stg_per_q[PER_W*int'(address) +: PER_W] <= writedata;
      if (address == ADDR_DIRENS) begin
        stg_dirs_q <= writedata[DIRS_LSB +: NUM_AXES];
        stg_ens_q  <= writedata[ENS_LSB +: NUM_AXES];
      end
      if (address == ADDR_DUR) stg_dur_q <= writedata;
    end
  end

  assign readdata  = readdata_q;
  assign sg_period = per_q;
  assign sg_dirs   = dirs_q;
  assign sg_ens    = ens_q;
  assign seg_done  = done_q;
  assign irq       = underrun_q | overflow_q | (run_q & (fifo_level <= LOW_WM_L));
endmodule

// File: tb/tb_motion_seg_sched.sv
// Self-checking bench for motion_seg_sched: random segments played against a
// queue-based timeline model of the scheduler.
module tb_motion_seg_sched;
  localparam int DEPTH  = 8;
  localparam int LOW_WM = 2;
  localparam logic [3:0] A_DIRENS = 4'd5, A_DUR = 4'd6, A_PUSH = 4'd7, A_CTRL = 4'd8, A_STAT = 4'd9;

  typedef struct packed {
    logic [159:0] per;
    logic [4:0]   dirs;
    logic [4:0]   ens;
    logic [31:0]  dur;
  } mseg_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         chipselect = 1'b0, read = 1'b0, write = 1'b0;
  logic [3:0]   address = '0;
  logic [31:0]  writedata = '0;
  logic [31:0]  readdata;
  logic [159:0] sg_period;
  logic [4:0]   sg_dirs, sg_ens;
  logic         seg_done, irq;

  int checks = 0;
  int errors = 0;
  int ens_cyc = 0;
  int done_cnt = 0;
  mseg_t model_q[$];
  bit model_ov = 1'b0;

  motion_seg_sched #(.DEPTH(DEPTH), .LOW_WM(LOW_WM)) dut (
    .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .read(read), .write(write),
    .address(address), .writedata(writedata), .readdata(readdata), .sg_period(sg_period),
    .sg_dirs(sg_dirs), .sg_ens(sg_ens), .seg_done(seg_done), .irq(irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset_n) begin
      if (sg_ens != 5'd0) ens_cyc <= ens_cyc + 1;
      if (seg_done) done_cnt <= done_cnt + 1;
    end
  end

  function automatic int seg_len(input logic [31:0] d);
    return (d == 32'd0) ? 1 : int'(d);
  endfunction

  function automatic logic [31:0] status_word(input int lvl, input bit busy, input bit ur, input bit ov);
    return {21'd0, ov, ur, busy, 8'(lvl)};
  endfunction

  function automatic mseg_t rand_seg(input int maxdur);
    mseg_t s;
    for (int a = 0; a < 5; a++) s.per[32*a +: 32] = $urandom;
    s.dirs = 5'($urandom);
    s.ens  = 5'($urandom);
    s.dur  = $urandom_range(maxdur, 0);
    return s;
  endfunction

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; read = 1'b1; address = a;
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
    d = readdata;
  endtask

  task automatic push_seg(input mseg_t s);
    for (int a = 0; a < 5; a++) bus_write(4'(a), s.per[32*a +: 32]);
    bus_write(A_DIRENS, {22'd0, s.ens, s.dirs});
    bus_write(A_DUR, s.dur);
    bus_write(A_PUSH, 32'd0);
    if (model_q.size() < DEPTH) model_q.push_back(s);
    else model_ov = 1'b1;
  endtask

  // Starts run, then walks the expected per-cycle timeline of the queued segments.
  task automatic run_and_check(input string name);
    int n, i, rem, total, d0;
    logic exp_done, exp_irq;
    logic [31:0] rd;
    n = model_q.size();
    total = 0;
    for (int j = 0; j < n; j++) total += seg_len(model_q[j].dur);
    d0 = done_cnt;
    bus_write(A_CTRL, 32'h1);
    i = 0;
    rem = seg_len(model_q[0].dur);
    for (int k = 0; k < total; k++) begin
      @(negedge clk);
      exp_done = (k > 0) && (rem == seg_len(model_q[i].dur));
      exp_irq  = ((n - 1 - i) <= LOW_WM);
      checks++;
      if (sg_ens !== model_q[i].ens || sg_dirs !== model_q[i].dirs || sg_period !== model_q[i].per) begin
        errors++;
        $display("FAIL %s cfg cycle %0d: got ens=%b dirs=%b per=%h, expected ens=%b dirs=%b per=%h",
                 name, k, sg_ens, sg_dirs, sg_period, model_q[i].ens, model_q[i].dirs, model_q[i].per);
      end
      checks++;
      if (seg_done !== exp_done) begin
        errors++;
        $display("FAIL %s seg_done cycle %0d: got %b expected %b", name, k, seg_done, exp_done);
      end
      checks++;
      if (irq !== exp_irq) begin
        errors++;
        $display("FAIL %s irq cycle %0d: got %b expected %b", name, k, irq, exp_irq);
      end
      rem--;
      if (rem == 0 && i < n - 1) begin
        i++;
        rem = seg_len(model_q[i].dur);
      end
    end
    @(negedge clk);
    checks++;
    if (sg_ens !== 5'd0 || seg_done !== 1'b1 || irq !== 1'b1) begin
      errors++;
      $display("FAIL %s end: got ens=%b done=%b irq=%b expected ens=00000 done=1 irq=1", name, sg_ens, seg_done, irq);
    end
    bus_read(A_STAT, rd);
    checks++;
    if (rd !== status_word(0, 0, 1, 0)) begin
      errors++;
      $display("FAIL %s status after underrun: got %h expected %h", name, rd, status_word(0, 0, 1, 0));
    end
    bus_read(A_CTRL, rd);
    checks++;
    if (rd !== 32'd0) begin
      errors++;
      $display("FAIL %s run after underrun: got %h expected 0", name, rd);
    end
    checks++;
    if (done_cnt - d0 !== n) begin
      errors++;
      $display("FAIL %s seg_done pulses: got %0d expected %0d", name, done_cnt - d0, n);
    end
    bus_write(A_CTRL, 32'h4);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL %s irq after clearing underrun: got %b expected 0", name, irq);
    end
    model_q.delete();
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    repeat (3) @(negedge clk);
    checks++;
    if (readdata !== 32'd0 || sg_period !== 160'd0 || sg_dirs !== 5'd0 || sg_ens !== 5'd0 ||
        seg_done !== 1'b0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL reset outputs: got rd=%h per=%h dirs=%b ens=%b done=%b irq=%b expected all 0",
               readdata, sg_period, sg_dirs, sg_ens, seg_done, irq);
    end
    reset_n = 1'b1;
    bus_read(A_STAT, rd);
    checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL reset status: got %h expected 0", rd); end
    bus_read(A_DUR, rd);
    checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL reset staging dur: got %h expected 0", rd); end
  endtask

  task automatic test_single();
    mseg_t s;
    s = '0;
    s.per[31:0] = 32'd100;
    s.ens = 5'b00001;
    s.dirs = 5'b00001;
    s.dur = 32'd10;
    push_seg(s);
    run_and_check("single");
  endtask

  task automatic test_back_to_back();
    mseg_t s;
    int durs[3] = '{5, 1, 0};
    for (int j = 0; j < 3; j++) begin
      s = rand_seg(0);
      s.dur = durs[j];
      push_seg(s);
    end
    run_and_check("back_to_back");
  endtask

  task automatic test_random();
    int n;
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(DEPTH, 1);
      for (int j = 0; j < n; j++) push_seg(rand_seg(6));
      run_and_check("random");
    end
  endtask

  task automatic test_push_while_running();
    mseg_t s;
    logic [31:0] rd;
    bus_write(A_CTRL, 32'h1);
    s = rand_seg(0);
    s.ens = 5'b11010;
    s.dur = 32'd3;
    push_seg(s);
    @(negedge clk);
    checks++;
    if (sg_ens !== s.ens || sg_period !== s.per) begin
      errors++;
      $display("FAIL push_running start: got ens=%b per=%h expected ens=%b per=%h", sg_ens, sg_period, s.ens, s.per);
    end
    repeat (3) @(negedge clk);
    bus_read(A_STAT, rd);
    checks++;
    if (rd !== status_word(0, 0, 1, 0)) begin
      errors++;
      $display("FAIL push_running status: got %h expected %h", rd, status_word(0, 0, 1, 0));
    end
    bus_write(A_CTRL, 32'h4);
    model_q.delete();
  endtask

  task automatic test_overflow();
    logic [31:0] rd;
    mseg_t last;
    model_ov = 1'b0;
    for (int j = 0; j <= DEPTH; j++) begin
      last = rand_seg(4);
      push_seg(last);
    end
    bus_read(A_STAT, rd);
    checks++;
    if (rd !== status_word(model_q.size(), 0, 0, model_ov)) begin
      errors++;
      $display("FAIL overflow status: got %h expected %h", rd, status_word(model_q.size(), 0, 0, model_ov));
    end
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL overflow irq: got %b expected 1", irq); end
    bus_read(A_DUR, rd);
    checks++;
    if (rd !== last.dur) begin errors++; $display("FAIL staging dur readback: got %h expected %h", rd, last.dur); end
    bus_read(A_DIRENS, rd);
    checks++;
    if (rd !== {22'd0, last.ens, last.dirs}) begin
      errors++;
      $display("FAIL staging direns readback: got %h expected %h", rd, {22'd0, last.ens, last.dirs});
    end
    bus_read(A_PUSH, rd);
    checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL push reg readback: got %h expected 0", rd); end
    bus_write(A_CTRL, 32'h8);
    bus_read(A_STAT, rd);
    checks++;
    if (rd !== status_word(DEPTH, 0, 0, 0)) begin
      errors++;
      $display("FAIL overflow clear: got %h expected %h", rd, status_word(DEPTH, 0, 0, 0));
    end
    model_ov = 1'b0;
    run_and_check("overflow_order");
  endtask

  task automatic test_abort();
    mseg_t s;
    logic [31:0] rd;
    int d0;
    s = rand_seg(0);
    s.ens = 5'b00111;
    s.dur = 32'd1000;
    push_seg(s);
    for (int j = 0; j < 3; j++) push_seg(rand_seg(5));
    bus_write(A_CTRL, 32'h1);
    repeat (20) @(negedge clk);
    d0 = done_cnt;
    bus_write(A_CTRL, 32'h2);
    checks++;
    if (sg_ens !== 5'd0) begin errors++; $display("FAIL abort ens: got %b expected 00000", sg_ens); end
    repeat (5) @(negedge clk);
    bus_read(A_STAT, rd);
    checks++;
    if (rd !== status_word(0, 0, 0, 0)) begin
      errors++;
      $display("FAIL abort status: got %h expected %h", rd, status_word(0, 0, 0, 0));
    end
    checks++;
    if (done_cnt !== d0) begin errors++; $display("FAIL abort seg_done: got %0d pulses expected 0", done_cnt - d0); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL abort irq: got %b expected 0", irq); end
    model_q.delete();
  endtask

  task automatic test_graceful();
    mseg_t s;
    logic [31:0] rd;
    int e0, d0;
    s = rand_seg(0);
    s.ens = 5'b10101;
    s.dur = 32'd50;
    push_seg(s);
    for (int j = 0; j < 2; j++) push_seg(rand_seg(5));
    e0 = ens_cyc;
    d0 = done_cnt;
    bus_write(A_CTRL, 32'h1);
    repeat (10) @(negedge clk);
    bus_write(A_CTRL, 32'h0);
    repeat (60) @(negedge clk);
    checks++;
    if (ens_cyc - e0 !== 50) begin errors++; $display("FAIL graceful active cycles: got %0d expected 50", ens_cyc - e0); end
    checks++;
    if (done_cnt - d0 !== 1) begin errors++; $display("FAIL graceful seg_done: got %0d expected 1", done_cnt - d0); end
    bus_read(A_STAT, rd);
    checks++;
    if (rd !== status_word(2, 0, 0, 0)) begin
      errors++;
      $display("FAIL graceful status: got %h expected %h", rd, status_word(2, 0, 0, 0));
    end
    bus_write(A_CTRL, 32'h2);
    model_q.delete();
  endtask

  task automatic test_reset_midrun();
    logic [31:0] rd;
    for (int j = 0; j < 2; j++) begin
      mseg_t s;
      s = rand_seg(0);
      s.ens = 5'b01110;
      s.dur = 32'd30;
      push_seg(s);
    end
    bus_write(A_CTRL, 32'h1);
    repeat (5) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (readdata !== 32'd0 || sg_period !== 160'd0 || sg_dirs !== 5'd0 || sg_ens !== 5'd0 ||
        seg_done !== 1'b0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL async reset outputs: got rd=%h per=%h dirs=%b ens=%b done=%b irq=%b expected all 0",
               readdata, sg_period, sg_dirs, sg_ens, seg_done, irq);
    end
    @(negedge clk);
    reset_n = 1'b1;
    bus_read(A_STAT, rd);
    checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL status after reset: got %h expected 0", rd); end
    bus_read(4'd0, rd);
    checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL staging per0 after reset: got %h expected 0", rd); end
    model_q.delete();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_random();
    test_push_while_running();
    test_overflow();
    test_abort();
    test_graceful();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no completion expected completion");
    $fatal(1, "watchdog");
  end
endmodule
